// File: rtl/riscoffee_pc_unit.sv
// Fetch program counter: trap / JALR / relative jump / RAS return / PC+4 selection with stall hold
// and a circular return-address stack. Optional target alignment check: RISCOFFEE_PC_MISALIGN_CHECK_EN.
module riscoffee_pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            STALL,
   input  logic            TRAP_EN,
   input  logic [XLEN-1:0] TRAP_VECTOR,
   input  logic            JALR_EN,
   input  logic [XLEN-1:0] JALR_TARGET,
   input  logic            JUMP_ENABLE,
   input  logic [XLEN-1:0] JUMP_OFFSET,
   input  logic            CALL,
   input  logic            RET,
   output logic [XLEN-1:0] PC,
   output logic            RAS_EMPTY,
   output logic            RAS_FULL,
   output logic            MISALIGN
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [XLEN-1:0] pcQ, pcD;
   logic [PW-1:0]   wrPtrQ, wrPtrD;
   logic [CW-1:0]   countQ, countD;
   logic            emptyQ, fullQ;
   logic            misalignQ, misalignD;

   logic [XLEN-1:0] rasMem [RAS_DEPTH];
   logic            rasWrEn;
   logic [PW-1:0]   rasWrAddr;
   logic [XLEN-1:0] rasWrData;

   logic [XLEN-1:0] pcPlus4, jalrTarget, jumpTarget, rasTop, target;
   logic [PW-1:0]   topPtr;
   logic            rasNonEmpty, rasFullNow, redirect, targetBad;

   assign pcPlus4     = pcQ + XLEN'(4);
   assign jalrTarget  = {JALR_TARGET[XLEN-1:1], 1'b0};
   assign jumpTarget  = pcQ + JUMP_OFFSET;
   assign topPtr      = wrPtrQ - PW'(1);
   assign rasTop      = rasMem[topPtr];
   assign rasNonEmpty = (countQ != '0);
   assign rasFullNow  = (countQ == CW'(RAS_DEPTH));

   // Redirect source below trap/stall; a RET on an empty stack is not a redirect.
   always_comb begin
      redirect = 1'b0;
      target   = pcPlus4;
      if (JALR_EN) begin
         redirect = 1'b1;
         target   = jalrTarget;
      end else if (JUMP_ENABLE) begin
         redirect = 1'b1;
         target   = jumpTarget;
      end else if (RET && rasNonEmpty) begin
         redirect = 1'b1;
         target   = rasTop;
      end
   end

`ifdef RISCOFFEE_PC_MISALIGN_CHECK_EN
   assign targetBad = redirect && (target[1:0] != 2'b00);
`else
   assign targetBad = 1'b0;
`endif

   // Next PC and stack update; a rejected target freezes both PC and stack for the cycle.
   always_comb begin
      pcD       = pcQ;
      wrPtrD    = wrPtrQ;
      countD    = countQ;
      misalignD = 1'b0;
      rasWrEn   = 1'b0;
      rasWrAddr = wrPtrQ;
      rasWrData = pcPlus4;
      if (TRAP_EN) begin
         pcD = TRAP_VECTOR;
      end else if (STALL) begin
         pcD = pcQ;
      end else if (targetBad) begin
         misalignD = 1'b1;
      end else begin
         pcD = target;
         if (CALL && RET && rasNonEmpty) begin
            rasWrEn   = 1'b1;
            rasWrAddr = topPtr;
         end else if (CALL) begin
            rasWrEn = 1'b1;
            wrPtrD  = wrPtrQ + PW'(1);
            if (!rasFullNow) countD = countQ + CW'(1);
         end else if (RET && rasNonEmpty) begin
            wrPtrD = topPtr;
            countD = countQ - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pcQ       <= RESET_VECTOR;
         wrPtrQ    <= '0;
         countQ    <= '0;
         emptyQ    <= 1'b1;
         fullQ     <= 1'b0;
         misalignQ <= 1'b0;
      end else begin
         pcQ       <= pcD;
         wrPtrQ    <= wrPtrD;
         countQ    <= countD;
         emptyQ    <= (countD == '0);
         fullQ     <= (countD == CW'(RAS_DEPTH));
         misalignQ <= misalignD;
      end
   end

   // Entry contents need no reset; the count alone decides validity.
   always_ff @(posedge CLK) begin
      if (RST_N && rasWrEn) rasMem[rasWrAddr] <= rasWrData;
   end

   assign PC        = pcQ;
   assign RAS_EMPTY = emptyQ;
   assign RAS_FULL  = fullQ;
   assign MISALIGN  = misalignQ;

endmodule
